// File: rtl/seg_disp_ctrl.sv
// Seven-segment display controller: CPU shadow registers, scan/blink pacing,
// and a debug source that can take over the display for a fixed hold time.
module seg_disp_ctrl #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  output logic        dbg_gnt,
  output logic        owner,
  output logic [31:0] disp_data,
  output logic [7:0]  digit_on,
  output logic        scan_tick
);

  localparam int SCAN_W  = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {ST_CPU, ST_DBG} state_t;

  state_t             state_q,       state_d;
  logic [31:0]        data_q,        data_d;
  logic [7:0]         blank_q,       blank_d;
  logic [7:0]         blink_q,       blink_d;
  logic [31:0]        dbg_val_q,     dbg_val_d;
  logic [HOLD_W-1:0]  hold_q,        hold_d;
  logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               scan_tick_q,   scan_tick_d;
  logic               dbg_gnt_q,     dbg_gnt_d;
  logic               owner_q,       owner_d;
  logic [31:0]        disp_data_q,   disp_data_d;
  logic [7:0]         digit_on_q,    digit_on_d;

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the block infers a latch.
    state_d       = state_q;
    data_d        = data_q;
    blank_d       = blank_q;
    blink_d       = blink_q;
    dbg_val_d     = dbg_val_q;
    hold_d        = hold_q;
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    dbg_gnt_d     = 1'b0;

    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
    scan_tick_d = (scan_cnt_d == SCAN_MAX);

    // Shadow registers accept writes regardless of who owns the display.
    if (cpu_we) begin
      case (cpu_addr)
        2'd0:    data_d  = cpu_wdata;
        2'd1:    blank_d = cpu_wdata[7:0];
        2'd2:    blink_d = cpu_wdata[7:0];
        default: ;
      endcase
    end

    case (state_q)
      ST_CPU: begin
        if (dbg_req) begin
          state_d   = ST_DBG;
          dbg_val_d = dbg_data;
          hold_d    = HOLD_MAX;
          dbg_gnt_d = 1'b1;
        end
      end
      default: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (dbg_req) begin
          dbg_val_d = dbg_data;
          hold_d    = HOLD_MAX;
          dbg_gnt_d = 1'b1;
        end else begin
          state_d = ST_CPU;
        end
      end
    endcase

    // Outputs are built from next-state values so the registered view
    // reflects a write or grant in the cycle right after its edge.
    owner_d = (state_d == ST_DBG);
    if (owner_d) begin
      disp_data_d = dbg_val_d;
      digit_on_d  = 8'hFF;
    end else begin
      disp_data_d = data_d;
      digit_on_d  = ~blank_d & ~(blink_d & {8{blink_phase_d}});
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CPU;
      data_q        <= '0;
      blank_q       <= '0;
      blink_q       <= '0;
      dbg_val_q     <= '0;
      hold_q        <= '0;
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_tick_q   <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      owner_q       <= 1'b0;
      disp_data_q   <= '0;
      digit_on_q    <= 8'hFF;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      blank_q       <= blank_d;
      blink_q       <= blink_d;
      dbg_val_q     <= dbg_val_d;
      hold_q        <= hold_d;
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_tick_q   <= scan_tick_d;
      dbg_gnt_q     <= dbg_gnt_d;
      owner_q       <= owner_d;
      disp_data_q   <= disp_data_d;
      digit_on_q    <= digit_on_d;
    end
  end

  assign dbg_gnt   = dbg_gnt_q;
  assign owner     = owner_q;
  assign disp_data = disp_data_q;
  assign digit_on  = digit_on_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl with small scan/blink/hold parameters;
// inputs change and outputs are sampled 1ns after each rising edge.
module tb_seg_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        dbg_req;
  logic [31:0] dbg_data;
  logic        dbg_gnt;
  logic        owner;
  logic [31:0] disp_data;
  logic [7:0]  digit_on;
  logic        scan_tick;

  int total = 0;
  int bad   = 0;

  seg_disp_ctrl #(.SCAN_DIV(4), .BLINK_TICKS(2), .HOLD_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dbg_req   (dbg_req),
    .dbg_data  (dbg_data),
    .dbg_gnt   (dbg_gnt),
    .owner     (owner),
    .disp_data (disp_data),
    .digit_on  (digit_on),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [31:0] wdata);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    step();
    cpu_we    = 1'b0;
  endtask

  task automatic check_view(input string tag, input logic own, input logic gnt,
                            input logic [31:0] data, input logic [7:0] dig);
    check({tag, ".owner"}, 32'(owner), 32'(own));
    check({tag, ".gnt"},   32'(dbg_gnt), 32'(gnt));
    check({tag, ".data"},  disp_data, data);
    check({tag, ".digit"}, 32'(digit_on), 32'(dig));
  endtask

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_data = '0;
    step(); step();
    check_view("reset", 1'b0, 1'b0, 32'h0, 8'hFF);
    check("reset.tick", 32'(scan_tick), 32'h0);
    rst = 1'b0;

    // Edges 1..8 after release: counter reaches 3 after edges 3 and 7.
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("tick%0d", i), 32'(scan_tick), 32'((i % 4) == 3));
    end

    // Edge 9: data write; blink phase already 1 but no masks yet.
    cpu_write(2'd0, 32'h1234ABCD);
    check_view("wr_data", 1'b0, 1'b0, 32'h1234ABCD, 8'hFF);
    cpu_write(2'd1, 32'h0000000F);                        // edge 10
    check("wr_blank", 32'(digit_on), 32'h000000F0);
    cpu_write(2'd2, 32'h00000030);                        // edge 11
    check("wr_blink", 32'(digit_on), 32'h000000C0);

    // Phase toggles at edges 16 and 24: C0 until 15, F0 16..23, C0 from 24.
    for (int i = 12; i <= 27; i++) begin
      step();
      check($sformatf("blink%0d", i), 32'(digit_on), (i < 16 || i >= 24) ? 32'hC0 : 32'hF0);
    end

    // Edge 28: digits 0-3 now have both blank and blink set; blank wins.
    cpu_write(2'd2, 32'h0000003F);
    check("blank_dom", 32'(digit_on), 32'h000000C0);

    // Edge 29: one-cycle debug request.
    dbg_req = 1'b1; dbg_data = 32'hDEADBEEF;
    step();
    dbg_req = 1'b0;
    check_view("grant1", 1'b1, 1'b1, 32'hDEADBEEF, 8'hFF);
    cpu_write(2'd0, 32'h00000042);                        // edge 30, during hold
    check_view("hold30", 1'b1, 1'b0, 32'hDEADBEEF, 8'hFF);
    for (int i = 31; i <= 36; i++) begin
      step();
      check_view($sformatf("hold%0d", i), 1'b1, 1'b0, 32'hDEADBEEF, 8'hFF);
    end
    // Edge 37: hold expired, CPU view returns with the write made during DBG (phase 0).
    dbg_req = 1'b0;
    step();
    check_view("return", 1'b0, 1'b0, 32'h00000042, 8'hF0);

    // Edge 38: grant with request held high; data changes mid-hold.
    dbg_req = 1'b1; dbg_data = 32'h11111111;
    step();
    check_view("grant2", 1'b1, 1'b1, 32'h11111111, 8'hFF);
    for (int i = 39; i <= 45; i++) begin
      step();
      if (i == 40) dbg_data = 32'h0000CAFE;
      check_view($sformatf("held%0d", i), 1'b1, 1'b0, 32'h11111111, 8'hFF);
    end
    step();                                               // edge 46: re-grant
    check_view("regrant", 1'b1, 1'b1, 32'h0000CAFE, 8'hFF);
    dbg_req = 1'b0;
    step();                                               // edge 47
    check_view("after_regrant", 1'b1, 1'b0, 32'h0000CAFE, 8'hFF);
    step();                                               // edge 48

    // Edge 49: reset mid-hold; edge 50: reset with a pending request in CPU state.
    rst = 1'b1; dbg_req = 1'b1;
    step();
    check_view("rst_hold", 1'b0, 1'b0, 32'h0, 8'hFF);
    step();
    check_view("rst_req", 1'b0, 1'b0, 32'h0, 8'hFF);
    rst = 1'b0; dbg_req = 1'b0;

    // Reserved address leaves all shadow registers alone.
    cpu_write(2'd3, 32'hFFFFFFFF);
    check_view("addr3", 1'b0, 1'b0, 32'h0, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
SEG_DISP_CTRL -- requirements
Module: seg_disp_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles per scan_tick period.
REQ-002 SHALL have parameter BLINK_TICKS, default 250: scan_ticks per blink half-period.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000000: clk cycles the debug owner holds the display.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port cpu_we  in  1  CPU register write strobe, one cycle per write.
REQ-007 SHALL have port cpu_addr  in  2  register select: 0 data, 1 blank mask, 2 blink mask, 3 reserved.
REQ-008 SHALL have port cpu_wdata  in  32  write data; masks use bits [7:0].
REQ-009 SHALL have port dbg_req  in  1  debug source requests the display (level).
REQ-010 SHALL have port dbg_data  in  32  debug value, sampled on grant.
REQ-011 SHALL have port dbg_gnt  out  1  one-cycle pulse when dbg_data is latched.
REQ-012 SHALL have port owner  out  1  0 = CPU owns display, 1 = debug owns.
REQ-013 SHALL have port disp_data  out  32  eight hex nibbles to the segment driver; nibble 7 leftmost.
REQ-014 SHALL have port digit_on  out  8  active-high per-digit enable; bit i = nibble i.
REQ-015 SHALL have port scan_tick  out  1  one-cycle pulse per SCAN_DIV cycles, paces digit scanning.

Function
REQ-016 SHALL hold shadow registers data_r[31:0], blank_r[7:0], blink_r[7:0]; cpu_we with addr 0/1/2 SHALL update the matching register at that edge; addr 3 SHALL be ignored.
REQ-017 SHALL accept CPU writes in both owner states; writes during debug ownership are shown only after return to CPU.
REQ-018 SHALL implement a scan counter 0..SCAN_DIV-1 that wraps; scan_tick SHALL be 1 in the cycle the counter equals SCAN_DIV-1, else 0.
REQ-019 SHALL count scan_ticks 0..BLINK_TICKS-1 and toggle blink_phase on each wrap of that count.
REQ-020 SHALL implement FSM states CPU and DBG; reset state CPU.
REQ-021 CPU -> DBG SHALL occur when dbg_req=1 in CPU: latch dbg_data, load hold counter with HOLD_CYCLES-1, pulse dbg_gnt, owner=1 next cycle.
REQ-022 In DBG the hold counter SHALL decrement each cycle; at 0 with dbg_req=0 -> CPU; at 0 with dbg_req=1 -> stay DBG, re-latch dbg_data, reload counter, pulse dbg_gnt again.
REQ-023 dbg_req deassertion before hold expiry SHALL NOT shorten the hold.
REQ-024 All outputs SHALL be registered; a CPU write or grant SHALL appear on disp_data/digit_on exactly one cycle after the write/grant edge.
REQ-025 In CPU state: disp_data = data_r; digit_on[i] = ~blank_r[i] & ~(blink_r[i] & blink_phase).
REQ-026 In DBG state: disp_data = latched debug value; digit_on = 8'hFF (masks ignored).
REQ-027 Simultaneous cpu_we and dbg_req in CPU SHALL both take effect: shadow updates and debug takes the display.
REQ-028 Blank SHALL dominate blink: a digit with both bits set is always off.

Reset
REQ-029 rst=1 at an edge SHALL force: data_r, blank_r, blink_r, latched debug value, disp_data = 0; digit_on = 8'hFF; owner, dbg_gnt, scan_tick, blink_phase = 0; all counters 0; FSM = CPU.
REQ-030 rst SHALL override any in-progress hold, write or grant in the same cycle; no dbg_gnt pulse while rst=1.

Verification (SCAN_DIV=4, BLINK_TICKS=2, HOLD_CYCLES=8)
REQ-031 Reset then cpu_we addr0 wdata 32'h1234ABCD -> next cycle disp_data=32'h1234ABCD, digit_on=8'hFF, owner=0.
REQ-032 Write blank 8'h0F, blink 8'h30 -> digit_on alternates 8'hF0 / 8'hC0, switching every 8 clk cycles; scan_tick every 4th cycle.
REQ-033 dbg_req=1 for 1 cycle with dbg_data 32'hDEADBEEF -> dbg_gnt 1 cycle, owner=1 and disp_data=32'hDEADBEEF, digit_on=8'hFF for 8 cycles, then previous CPU view restored.
REQ-034 During DBG, cpu_we addr0 32'h00000042 -> disp_data unchanged until hold expiry, then 32'h00000042.
REQ-035 dbg_req held high, dbg_data changes to 32'h0000CAFE mid-hold -> second dbg_gnt at expiry, disp_data=32'h0000CAFE, owner stays 1.
REQ-036 rst pulsed mid-hold -> next cycle owner=0, disp_data=0, digit_on=8'hFF, no dbg_gnt.
